perceptron: RTL and testbench



---
 rtl/perceptron.sv | 159 +++++++++++++++
 tb/tb_perceptron.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/perceptron.sv
// perceptron: one fixed-point neuron with forward inference, back-propagated
// local gradient and in-place gradient-descent weight update.
// Numbers are 64-bit signed Q32.32 (ONE = 2^32).
// activation encoding: 2'd0 Linear, 2'd1 ReLU, 2'd2 Sigmoid (2'd3 acts as Linear).
// Optional build macro: PERCEPTRON_BIAS_EN adds a trained bias register;
// without it the bias is a constant zero.
module perceptron #(
    parameter int unsigned input_units  = 2,
    parameter int unsigned output_units = 1,
    localparam int unsigned W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] values [input_units],
    input  logic [1:0]          activation,
    input  logic                training,
    input  logic signed [W-1:0] learning_rate,
    input  logic signed [W-1:0] next_layer_weights [output_units],
    input  logic signed [W-1:0] error_gradient_next_layer [output_units],
    output logic signed [W-1:0] prediction,
    output logic signed [W-1:0] error_gradient,
    output logic signed [W-1:0] current_weights [input_units]
);

    localparam int unsigned PW   = 2 * W;
    localparam int unsigned FRAC = 32;

    typedef logic signed [W-1:0] sfp;

    localparam logic [1:0] ACT_LINEAR  = 2'd0;
    localparam logic [1:0] ACT_RELU    = 2'd1;
    localparam logic [1:0] ACT_SIGMOID = 2'd2;

    localparam sfp ZERO      = 64'sh0000_0000_0000_0000;
    localparam sfp ONE       = 64'sh0000_0001_0000_0000;
    localparam sfp HALF      = 64'sh0000_0000_8000_0000;
    localparam sfp C_0_625   = 64'sh0000_0000_A000_0000;
    localparam sfp C_0_84375 = 64'sh0000_0000_D800_0000;
    localparam sfp C_2_375   = 64'sh0000_0002_6000_0000;
    localparam sfp C_5       = 64'sh0000_0005_0000_0000;
    localparam sfp SFP_MAX   = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam sfp SFP_MIN   = 64'sh8000_0000_0000_0000;

    // Clamp a wide intermediate into the 64-bit range.
    function automatic sfp sat(input logic signed [PW-1:0] x);
        if (x > PW'(SFP_MAX)) return SFP_MAX;
        if (x < PW'(SFP_MIN)) return SFP_MIN;
        return sfp'(x[W-1:0]);
    endfunction

    function automatic sfp sat_add(input sfp a, input sfp b);
        return sat(PW'(a) + PW'(b));
    endfunction

    function automatic sfp sat_sub(input sfp a, input sfp b);
        return sat(PW'(a) - PW'(b));
    endfunction

    // Full 128-bit product, rescaled back to Q32.32.
    function automatic sfp sat_mul(input sfp a, input sfp b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return sat(p >>> FRAC);
    endfunction

    // Piecewise-linear sigmoid evaluated on |z|, mirrored for negative z.
    function automatic sfp sigmoid(input sfp z);
        sfp mag;
        sfp y;
        mag = (z < ZERO) ? sat_sub(ZERO, z) : z;
        if (mag >= C_5)            y = ONE;
        else if (mag >= C_2_375)   y = sat_add(mag >>> 5, C_0_84375);
        else if (mag >= ONE)       y = sat_add(mag >>> 3, C_0_625);
        else                       y = sat_add(mag >>> 2, HALF);
        return (z < ZERO) ? sat_sub(ONE, y) : y;
    endfunction

    sfp         w_q [input_units];
    sfp         x_q [input_units];
    sfp         z_q;
    logic [1:0] act_q;
    logic       train_q;
    sfp         bias_c;
    sfp         z_c;
    sfp         a_c;
    sfp         step_c;

    // Forward pass: weighted sum plus bias, then the selected activation.
    always_comb begin
        sfp acc;
        acc = ZERO;
        for (int i = 0; i < int'(input_units); i++) begin
            acc = sat_add(acc, sat_mul(w_q[i], values[i]));
        end
        z_c = sat_add(acc, bias_c);
        case (activation)
            ACT_RELU:    a_c = (z_c > ZERO) ? z_c : ZERO;
            ACT_SIGMOID: a_c = sigmoid(z_c);
            default:     a_c = z_c;
        endcase
    end

    // Backward pass for the registered sample: downstream sum times act'.
    always_comb begin
        sfp s;
        sfp deriv;
        s = ZERO;
        for (int k = 0; k < int'(output_units); k++) begin
            s = sat_add(s, sat_mul(next_layer_weights[k], error_gradient_next_layer[k]));
        end
        case (act_q)
            ACT_RELU:    deriv = (z_q > ZERO) ? ONE : ZERO;
            ACT_SIGMOID: deriv = sat_mul(prediction, sat_sub(ONE, prediction));
            default:     deriv = ONE;
        endcase
        error_gradient = sat_mul(s, deriv);
        step_c         = sat_mul(learning_rate, error_gradient);
    end

    // Sample capture and weight update; reset wins over a pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            prediction <= ZERO;
            z_q        <= ZERO;
            act_q      <= ACT_LINEAR;
            train_q    <= 1'b0;
            for (int i = 0; i < int'(input_units); i++) begin
                x_q[i] <= ZERO;
                w_q[i] <= ZERO;
            end
        end else begin
            prediction <= a_c;
            z_q        <= z_c;
            act_q      <= activation;
            train_q    <= training;
            for (int i = 0; i < int'(input_units); i++) begin
                x_q[i] <= values[i];
                if (train_q) w_q[i] <= sat_sub(w_q[i], sat_mul(step_c, x_q[i]));
            end
        end
    end

`ifdef PERCEPTRON_BIAS_EN
    sfp bias_q;

    // Bias register trained alongside the weights.
    always_ff @(posedge clk) begin
        if (rst)          bias_q <= ZERO;
        else if (train_q) bias_q <= sat_sub(bias_q, step_c);
    end

    assign bias_c = bias_q;
`else
    assign bias_c = ZERO;
`endif

    assign current_weights = w_q;

endmodule

// File: tb/tb_perceptron.sv
// tb_perceptron: directed bench with a prediction scoreboard and immediate
// assertions on weights and error gradient.
module tb_perceptron;

    localparam int unsigned NI = 2;
    localparam int unsigned NO = 1;

    typedef logic signed [63:0] sfp;

    localparam logic [1:0] LINEAR  = 2'd0;
    localparam logic [1:0] RELU    = 2'd1;
    localparam logic [1:0] SIGMOID = 2'd2;

    localparam sfp ZERO    = 64'sh0000_0000_0000_0000;
    localparam sfp ONE     = 64'sh0000_0001_0000_0000;
    localparam sfp TWO     = 64'sh0000_0002_0000_0000;
    localparam sfp HALF    = 64'sh0000_0000_8000_0000;
    localparam sfp QUARTER = 64'sh0000_0000_4000_0000;
    localparam sfp C_3_16  = 64'sh0000_0000_3000_0000;
    localparam sfp NEG1    = -64'sh0000_0001_0000_0000;
    localparam sfp NEG2    = -64'sh0000_0002_0000_0000;
    localparam sfp NEG3    = -64'sh0000_0003_0000_0000;

`ifdef PERCEPTRON_BIAS_EN
    localparam sfp B1 = NEG1;
`else
    localparam sfp B1 = ZERO;
`endif

    logic       clk;
    logic       rst;
    logic       training;
    logic [1:0] activation;
    sfp         values [NI];
    sfp         learning_rate;
    sfp         nlw [NO];
    sfp         egn [NO];
    sfp         prediction;
    sfp         error_gradient;
    sfp         current_weights [NI];

    int checks = 0;
    int errors = 0;
    sfp    exp_q [$];
    string tag_q [$];

    perceptron #(.input_units(NI), .output_units(NO)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .values                    (values),
        .activation                (activation),
        .training                  (training),
        .learning_rate             (learning_rate),
        .next_layer_weights        (nlw),
        .error_gradient_next_layer (egn),
        .prediction                (prediction),
        .error_gradient            (error_gradient),
        .current_weights           (current_weights)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input sfp obs, input sfp exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input sfp e0, input sfp e1);
        check({tag, "_w0"}, current_weights[0], e0);
        check({tag, "_w1"}, current_weights[1], e1);
    endtask

    // Present one sample and queue the prediction it must produce.
    task automatic drive(input string tag, input logic [1:0] act, input sfp v0,
                         input sfp v1, input logic tr, input sfp exp);
        activation = act;
        values[0]  = v0;
        values[1]  = v1;
        training   = tr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Advance one clock and retire the oldest queued prediction.
    task automatic tick();
        sfp    e;
        string t;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, prediction, e);
        end
    endtask

    initial begin
        rst           = 1'b1;
        training      = 1'b0;
        activation    = LINEAR;
        values[0]     = ONE;
        values[1]     = ONE;
        learning_rate = ONE;
        nlw[0]        = ONE;
        egn[0]        = ONE;

        // Reset for three cycles
        repeat (3) tick();
        check("rst_pred", prediction, ZERO);
        check_w("rst", ZERO, ZERO);
        check("rst_grad", error_gradient, ONE);
        rst = 1'b0;

        // Sigmoid at zero weights
        drive("sig_zero", SIGMOID, ONE, ONE, 1'b0, HALF);
        tick();
        check("sig_zero_grad", error_gradient, QUARTER);

        // One Linear training step
        drive("lin_train", LINEAR, ONE, ONE, 1'b1, ZERO);
        tick();
        check("lin_train_grad", error_gradient, ONE);
        drive("pre_update", LINEAR, ZERO, ZERO, 1'b0, ZERO);
        tick();
        check_w("lin_train", NEG1, NEG1);
        drive("post_update", LINEAR, ONE, ONE, 1'b0, NEG2 + B1);
        tick();
        check_w("hold", NEG1, NEG1);

        // Activation shapes with trained weights
        drive("sig_sat", SIGMOID, NEG3, NEG3, 1'b0, ONE);
        tick();
        check("sig_sat_grad", error_gradient, ZERO);
        drive("sig_neg1", SIGMOID, ONE + B1, ZERO, 1'b0, QUARTER);
        tick();
        check("sig_neg1_grad", error_gradient, C_3_16);
        drive("relu_neg", RELU, ONE, ONE, 1'b0, ZERO);
        tick();
        check("relu_neg_grad", error_gradient, ZERO);

        // Reset in the middle of a training step
        drive("mid_train", LINEAR, ONE, ONE, 1'b1, NEG2 + B1);
        tick();
        check("mid_train_grad", error_gradient, ONE);
        rst      = 1'b1;
        training = 1'b0;
        tick();
        check("mid_rst_pred", prediction, ZERO);
        check_w("mid_rst", ZERO, ZERO);
        rst = 1'b0;
        drive("after_rst", LINEAR, ONE, ONE, 1'b0, ZERO);
        tick();
        check_w("after_rst", ZERO, ZERO);

        // Training gate held low
        for (int c = 0; c < 5; c++) begin
            drive("gate", LINEAR, ONE, ONE, 1'b0, ZERO);
            tick();
            check_w("gate", ZERO, ZERO);
        end

        // Per-input update with a non-unit rate and gradient
        learning_rate = HALF;
        egn[0]        = TWO;
        drive("train2", LINEAR, TWO, ONE, 1'b1, ZERO);
        tick();
        check("train2_grad", error_gradient, TWO);
        drive("train2_pre", LINEAR, ZERO, ZERO, 1'b0, ZERO);
        tick();
        check_w("train2", NEG2, NEG1);
        learning_rate = ONE;
        egn[0]        = ONE;
        drive("train2_inf", LINEAR, ONE, ONE, 1'b0, NEG3 + B1);
        tick();
        check_w("train2_hold", NEG2, NEG1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
